// File: rtl/note_pkg.sv
// Shared types and screen constants for the note scroller.
// Imported by the scroller top and its helpers.
package note_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    WAIT_FRAME,
    ERASE,
    MOVE
  } state_t;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int SQUARE_SIZE = 4;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;

endpackage

// File: rtl/note_scroller_if.sv
// Square request bus from the note scroller to the 4x4 drawer.
// Values are held stable for the whole sweep after each go pulse.
interface note_scroller_if;

  logic [7:0] sq_x;
  logic [6:0] sq_y;
  logic [2:0] sq_colour;
  logic       sq_go;

  modport master (
    output sq_x,
    output sq_y,
    output sq_colour,
    output sq_go
  );

  modport slave (
    input sq_x,
    input sq_y,
    input sq_colour,
    input sq_go
  );

endinterface

// File: rtl/tick_counter.sv
// Loadable down-counter; done is high once the count reaches zero.
// Loading N-1 makes done rise on the Nth cycle after the load.
module tick_counter #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/note_scroller.sv
// Moves one note sprite left along a lane, erasing and redrawing
// it each frame, and reports hit (scored) or expiry (missed).
module note_scroller
  import note_pkg::*;
#(
  parameter int FRAME_TICKS = 833333,
  parameter int DRAW_HOLD   = 17,
  parameter int START_X     = 156,
  parameter int LANE_Y      = 56,
  parameter int HIT_X       = 16,
  parameter int STEP        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spawn,
  input  logic [2:0]       spawn_colour,
  input  logic             hit,
  note_scroller_if.master  drw,
  output logic             active,
  output logic [7:0]       note_x,
  output logic             scored,
  output logic             missed
);

  localparam int MAXT =
    (FRAME_TICKS > DRAW_HOLD) ? FRAME_TICKS : DRAW_HOLD;
  localparam int CW = $clog2(MAXT + 1);

  localparam logic [CW-1:0] HOLD_LD  = CW'(DRAW_HOLD - 1);
  localparam logic [CW-1:0] FRAME_LD = CW'(FRAME_TICKS - 1);
  localparam logic [8:0]    EXP_LIM  = 9'(HIT_X + STEP);
  localparam logic [7:0]    X0       = 8'(START_X);
  localparam logic [6:0]    Y0       = 7'(LANE_Y);
  localparam logic [7:0]    DX       = 8'(STEP);

  state_t        state;
  logic [2:0]    colour;
  logic          hit_latch;
  logic          load;
  logic [CW-1:0] ld_val;
  logic          done;
  logic [7:0]    nx;
  logic          expire;

  assign nx     = note_x - DX;
  assign expire = ({1'b0, note_x} < EXP_LIM);

  always_comb begin
    load   = 1'b0;
    ld_val = HOLD_LD;
    case (state)
      IDLE:       load = spawn;
      DRAW: begin
        load   = done;
        ld_val = FRAME_LD;
      end
      WAIT_FRAME: load = done;
      MOVE:       load = 1'b1;
      default:    load = 1'b0;
    endcase
  end

  tick_counter #(
    .W(CW)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .value(ld_val),
    .done (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      note_x        <= '0;
      colour        <= '0;
      hit_latch     <= 1'b0;
      active        <= 1'b0;
      scored        <= 1'b0;
      missed        <= 1'b0;
      drw.sq_x      <= '0;
      drw.sq_y      <= '0;
      drw.sq_colour <= '0;
      drw.sq_go     <= 1'b0;
    end else begin
      drw.sq_go <= 1'b0;
      scored    <= 1'b0;
      missed    <= 1'b0;
      if (hit && active) hit_latch <= 1'b1;
      case (state)
        IDLE: begin
          if (spawn) begin
            note_x        <= X0;
            colour        <= spawn_colour;
            hit_latch     <= 1'b0;
            active        <= 1'b1;
            drw.sq_go     <= 1'b1;
            drw.sq_x      <= X0;
            drw.sq_y      <= Y0;
            drw.sq_colour <= spawn_colour;
            state         <= DRAW;
          end
        end
        DRAW: begin
          if (done) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (done) begin
            drw.sq_go     <= 1'b1;
            drw.sq_x      <= note_x;
            drw.sq_y      <= Y0;
            drw.sq_colour <= COLOUR_BLACK;
            state         <= ERASE;
          end
        end
        ERASE: begin
          if (done) begin
            // a pending hit wins over expiry on the same frame
            if (hit_latch) begin
              scored    <= 1'b1;
              hit_latch <= 1'b0;
              active    <= 1'b0;
              state     <= IDLE;
            end else if (expire) begin
              missed    <= 1'b1;
              hit_latch <= 1'b0;
              active    <= 1'b0;
              state     <= IDLE;
            end else begin
              state <= MOVE;
            end
          end
        end
        MOVE: begin
          note_x        <= nx;
          drw.sq_go     <= 1'b1;
          drw.sq_x      <= nx;
          drw.sq_y      <= Y0;
          drw.sq_colour <= colour;
          state         <= DRAW;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_scroller.sv
// Bench for note_scroller: frame-schedule model plus directed cases.
// Outputs are compared every negedge against the model.
module tb_note_scroller;

  localparam int FT   = 4;
  localparam int DH   = 17;
  localparam int SX   = 40;
  localparam int LY   = 56;
  localparam int HX   = 36;
  localparam int ST   = 2;
  localparam int FP   = DH + FT + DH + 1;
  localparam int ERO  = DH + FT;
  localparam int ENDO = FP - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       spawn;
  logic [2:0] spawn_colour;
  logic       hit;
  logic       active;
  logic [7:0] note_x;
  logic       scored;
  logic       missed;

  note_scroller_if drw();

  note_scroller #(
    .FRAME_TICKS(FT),
    .DRAW_HOLD  (DH),
    .START_X    (SX),
    .LANE_Y     (LY),
    .HIT_X      (HX),
    .STEP       (ST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spawn       (spawn),
    .spawn_colour(spawn_colour),
    .hit         (hit),
    .drw         (drw),
    .active      (active),
    .note_x      (note_x),
    .scored      (scored),
    .missed      (missed)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int expire_frame();
    for (int k = 0; k < 256; k++)
      if (SX - ST * k < HX + ST) return k;
    return 255;
  endfunction

  // Model: note life is a schedule of fixed-length frames from spawn.
  int         n = 0;
  int         s = 0;
  int         kf = 0;
  int         last_go = -1;
  bit         on = 1'b0;
  bit         hit_taken = 1'b0;
  bit         scr = 1'b0;
  logic [2:0] mcol = '0;
  logic       e_active = 1'b0;
  logic [7:0] e_x = '0;
  logic [7:0] e_sqx = '0;
  logic [6:0] e_sqy = '0;
  logic [2:0] e_col = '0;
  logic       e_go = 1'b0;
  logic       e_scored = 1'b0;
  logic       e_missed = 1'b0;

  always @(posedge clk) begin
    int r, f, p, k;
    n++;
    e_go     = 1'b0;
    e_scored = 1'b0;
    e_missed = 1'b0;
    if (reset) begin
      on       = 1'b0;
      e_active = 1'b0;
      e_x      = '0;
      e_sqx    = '0;
      e_sqy    = '0;
      e_col    = '0;
      last_go  = -1;
    end else begin
      if (!on && spawn) begin
        s         = n;
        on        = 1'b1;
        mcol      = spawn_colour;
        kf        = expire_frame();
        hit_taken = 1'b0;
        scr       = 1'b0;
      end else if (on && hit && !hit_taken) begin
        k = 0;
        while (!(n < s + FP * k + ENDO)) k++;
        hit_taken = 1'b1;
        if (k <= kf) begin
          kf  = k;
          scr = 1'b1;
        end
      end
      if (on) begin
        r        = n - s;
        f        = r / FP;
        p        = r % FP;
        e_x      = 8'(SX - ST * f);
        e_sqx    = e_x;
        e_sqy    = 7'(LY);
        e_col    = (p < ERO) ? mcol : 3'b000;
        e_go     = (p == 0) || (p == ERO);
        e_active = 1'b1;
        if (r == FP * kf + ENDO) begin
          e_active = 1'b0;
          e_go     = 1'b0;
          if (scr) e_scored = 1'b1;
          else     e_missed = 1'b1;
          on = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (n > 0) begin
      chk("active", active, e_active);
      chk("note_x", note_x, e_x);
      chk("sq_x", drw.sq_x, e_sqx);
      chk("sq_y", drw.sq_y, e_sqy);
      chk("sq_colour", drw.sq_colour, e_col);
      chk("sq_go", drw.sq_go, e_go);
      chk("scored", scored, e_scored);
      chk("missed", missed, e_missed);
      if (drw.sq_go === 1'b1) begin
        if (last_go >= 0) chk("go_gap_ok", (n - last_go) >= DH, 1);
        last_go = n;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    reset        = 1'b1;
    spawn        = 1'b0;
    hit          = 1'b0;
    spawn_colour = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_active", active, 0);
    chk("rst_note_x", note_x, 0);
    chk("rst_sq_go", drw.sq_go, 0);
    reset = 1'b0;
    @(negedge clk);

    spawn        = 1'b1;
    spawn_colour = 3'b100;
    @(negedge clk);
    spawn = 1'b0;
    chk("spawn_go", drw.sq_go, 1);
    chk("spawn_x", drw.sq_x, 40);
    chk("spawn_y", drw.sq_y, 56);
    chk("spawn_col", drw.sq_colour, 4);
    chk("spawn_active", active, 1);
    for (cnt = 1; cnt <= 300; cnt++) begin
      spawn        = (cnt == 30) || (cnt == 60);
      spawn_colour = spawn ? 3'b111 : 3'b100;
      @(negedge clk);
      if (missed) break;
    end
    spawn = 1'b0;
    chk("miss_at", cnt, 116);
    chk("miss_x", note_x, 36);
    chk("miss_sq_col", drw.sq_colour, 0);

    hit = 1'b1;
    repeat (2) @(negedge clk);
    hit = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_active", active, 0);

    spawn        = 1'b1;
    spawn_colour = 3'b011;
    @(negedge clk);
    spawn = 1'b0;
    for (cnt = 1; cnt <= 300; cnt++) begin
      hit = (cnt == 57) || (cnt == 60);
      @(negedge clk);
      if (scored) break;
    end
    hit = 1'b0;
    chk("score_at", cnt, 77);
    chk("score_x", note_x, 38);
    chk("score_sq_x", drw.sq_x, 38);
    chk("score_missed", missed, 0);
    repeat (4) @(negedge clk);

    spawn        = 1'b1;
    spawn_colour = 3'b010;
    @(negedge clk);
    spawn = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_active", active, 0);
    chk("mid_rst_sq_x", drw.sq_x, 0);
    chk("mid_rst_col", drw.sq_colour, 0);
    spawn        = 1'b1;
    hit          = 1'b1;
    spawn_colour = 3'b101;
    @(negedge clk);
    spawn = 1'b0;
    hit   = 1'b0;
    chk("respawn_x", drw.sq_x, 40);
    chk("respawn_col", drw.sq_colour, 5);
    for (cnt = 1; cnt <= 300; cnt++) begin
      @(negedge clk);
      if (missed) break;
    end
    chk("remiss_at", cnt, 116);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_scroller.md
# note_scroller

Upstream sequencer for the 4x4 square drawer. It moves one note sprite leftward along a single lane, one step per frame. Each frame it erases the note at its old position, then redraws it at the new one. It issues one coordinate/colour set plus a one-cycle `sq_go` per square and holds the values stable for the drawer's full 16-pixel sweep. It reports when the note is hit by the player or reaches the hit line unhit (miss).

## Interface
Parameters:
- `FRAME_TICKS`, 833333: clk cycles per movement frame (60 Hz at 50 MHz); minimum 2.
- `DRAW_HOLD`, 17: cycles coordinates are held per square (1 cycle go-to-P1 latency + 16 pixels).
- `START_X`, 156: spawn x (8-bit).
- `LANE_Y`, 56: fixed y of the lane (7-bit).
- `HIT_X`, 16: leftmost x the note may occupy.
- `STEP`, 1: pixels moved per frame, 1..15.

Ports:
- `clk`, in, 1: system clock (CLOCK_50).
- `reset`, in, 1: synchronous, active-high.
- `spawn`, in, 1: single-cycle request to start a note.
- `spawn_colour`, in, 3: note colour, latched on an accepted spawn.
- `hit`, in, 1: single-cycle player hit.
- `sq_x`, out, 8: square origin x to the drawer.
- `sq_y`, out, 7: square origin y to the drawer.
- `sq_colour`, out, 3: colour to the drawer.
- `sq_go`, out, 1: one-cycle start pulse to the drawer.
- `active`, out, 1: a note is on screen.
- `note_x`, out, 8: current logical x.
- `scored`, out, 1: one-cycle pulse on a successful hit.
- `missed`, out, 1: one-cycle pulse when the note expires.

## Operation
States: IDLE, DRAW, WAIT_FRAME, ERASE, MOVE.
- IDLE: `active`=0. When `spawn`=1:
  - `note_x` ← START_X; colour latched.
  - Go to DRAW.
- DRAW:
  - On entry: `sq_go`=1 for one cycle, `sq_colour`=latched colour, `sq_x`=`note_x`, `sq_y`=LANE_Y.
  - Stay DRAW_HOLD cycles, then go to WAIT_FRAME.
- WAIT_FRAME:
  - Count FRAME_TICKS cycles, then go to ERASE.
- ERASE:
  - Same as DRAW, but `sq_colour`=3'b000.
  - After DRAW_HOLD cycles: if the hit latch is set or the expire condition holds, go to IDLE. Otherwise go to MOVE.
- MOVE (1 cycle): `note_x` ← `note_x` − STEP; go to DRAW.
- Expire condition: `note_x` < HIT_X + STEP. Compute it in 9 bits so there is no wrap-around.
- Hit handling:
  - A `hit` while `active` sets a latch; later hits are ignored.
  - On leaving ERASE with the latch set: pulse `scored`, clear the latch, go to IDLE.
  - Hit takes priority over expiry, so `missed` does not pulse.
- Expiry without a hit: pulse `missed`.
- `spawn` while `active` is ignored (no queueing).
- `hit` while IDLE is ignored.
- `spawn` and `hit` in the same IDLE cycle: spawn is accepted, hit is dropped.

## Timing
- Reset: state IDLE, counters 0, `note_x`=0, `sq_x`/`sq_y`/`sq_colour`=0, `sq_go`/`active`/`scored`/`missed`=0. Reset mid-draw abandons the square immediately and leaves a partial sprite; no erase is issued.
- `spawn` at cycle t: DRAW is entered at t+1, with `sq_go`=1 at t+1.
- `sq_x`, `sq_y`, `sq_colour` are registered. They change only in the cycle `sq_go` rises and stay constant for DRAW_HOLD cycles.
- `sq_go` is never high on two consecutive cycles. Successive pulses are ≥ DRAW_HOLD cycles apart.
- One frame period = DRAW_HOLD + FRAME_TICKS + DRAW_HOLD + 1 cycles.
- `scored`/`missed` assert in the cycle IDLE is entered. `active` falls in that same cycle.

## Structure
- Package `note_pkg`:
  - State enum.
  - SCREEN_W=160, SCREEN_H=120, COLOUR_BLACK=3'b000, SQUARE_SIZE=4.
- Sub-module `tick_counter`:
  - Loadable down-counter with a `done` flag.
  - One instance times DRAW_HOLD and FRAME_TICKS, reloaded on each state entry.

## Test plan
Bench parameters: FRAME_TICKS=4, DRAW_HOLD=17, START_X=40, HIT_X=36, STEP=2.
- Reset, then `spawn` with colour 3'b100 → `sq_go` one cycle later with (40,56,100); values stable for 17 cycles; `active`=1.
- Free run after spawn → `sq_go` sequence alternates draw/erase: draws at x=40, 38, 36; last erase at x=36 (colour 000); then `missed`=1 for 1 cycle, `active`=0, no further `sq_go`.
- `hit` during the second WAIT_FRAME → erase at x=38, `scored`=1, `missed` stays 0, next state IDLE.
- `spawn` repeated while active, plus `hit` while IDLE → no effect on `note_x`, colour, or pulses.
- `reset` asserted in the middle of DRAW → next cycle all outputs 0 and state IDLE; a following `spawn` restarts at x=40.
- Every `sq_go` → ≥17 cycles since the previous `sq_go`; coordinates never change between pulses.
